// File: rtl/mips_pkg.sv
// Shared encodings for the EX-stage destination select and register-file constants.
package mips_pkg;

  // EX_reg_dst encodings; the reserved code decodes like rt.
  typedef enum logic [1:0] {
    RegDstRt   = 2'b00,
    RegDstRd   = 2'b01,
    RegDstLink = 2'b10,
    RegDstRsvd = 2'b11
  } reg_dst_e;

  localparam int unsigned REG_ZERO         = 0;
  localparam int unsigned LINK_REG_DEFAULT = 31;

endpackage

// File: rtl/dest_match.sv
// Single-source priority comparator: finds the youngest in-flight stage writing i_src.
module dest_match
  import mips_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned SW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [REG_W-1:0]       i_src,
  input  logic [DEPTH*REG_W-1:0] i_stage_dest,
  input  logic [DEPTH-1:0]       i_stage_wr,
  output logic                   o_hit,
  output logic [SW-1:0]          o_hit_stage
);

  logic w_src_nz;
  assign w_src_nz = (i_src != REG_W'(REG_ZERO));

  // Scan oldest to youngest so the lowest matching index is the one left standing.
  always_comb begin
    o_hit       = 1'b0;
    o_hit_stage = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_src_nz && i_stage_wr[i] && (i_stage_dest[i*REG_W +: REG_W] == i_src)) begin
        o_hit       = 1'b1;
        o_hit_stage = SW'(i);
      end
    end
  end

endmodule

// File: rtl/ex_dest_pipe.sv
// EX-stage destination select plus post-EX destination tracking with hazard match outputs.
module ex_dest_pipe
  import mips_pkg::*;
#(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned LINK_REG = LINK_REG_DEFAULT,
  parameter int unsigned NUM_SRC  = 2,
  localparam int unsigned SW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REG_W-1:0]         EX_rt,
  input  logic [REG_W-1:0]         EX_rd,
  input  logic [1:0]               EX_reg_dst,
  input  logic                     EX_reg_write,
  input  logic                     EX_valid,
  input  logic                     stall,
  input  logic                     flush,
  output logic [REG_W-1:0]         EX_rd_mux,
  output logic [DEPTH*REG_W-1:0]   stage_dest,
  output logic [DEPTH-1:0]         stage_wr,
  input  logic [NUM_SRC*REG_W-1:0] src_addr,
  output logic [NUM_SRC-1:0]       src_hit,
  output logic [NUM_SRC*SW-1:0]    src_hit_stage
);

  logic [REG_W-1:0] w_dest_sel;
  logic             w_eff_wr;
  logic [REG_W-1:0] r_dest [DEPTH];
  logic [DEPTH-1:0] r_wr;

  // Destination select from the 2-bit mode; reserved code falls through to rt.
  always_comb begin
    w_dest_sel = EX_rt;
    case (reg_dst_e'(EX_reg_dst))
      RegDstRd:   w_dest_sel = EX_rd;
      RegDstLink: w_dest_sel = REG_W'(LINK_REG);
      default:    w_dest_sel = EX_rt;
    endcase
  end

  assign EX_rd_mux = w_dest_sel;
  // Writes to $0 are architecturally discarded, so never track them.
  assign w_eff_wr  = EX_valid & EX_reg_write & (w_dest_sel != REG_W'(REG_ZERO));

  // Stage shift register: flush bubbles stage 0 even under stall; stall freezes the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_dest[i] <= '0;
      end
      r_wr <= '0;
    end else begin
      if (flush) begin
        r_dest[0] <= '0;
        r_wr[0]   <= 1'b0;
      end else if (!stall) begin
        r_dest[0] <= w_dest_sel;
        r_wr[0]   <= w_eff_wr;
      end
      if (!stall) begin
        for (int i = 1; i < DEPTH; i++) begin
          r_dest[i] <= r_dest[i-1];
          r_wr[i]   <= r_wr[i-1];
        end
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage_out
    assign stage_dest[gi*REG_W +: REG_W] = r_dest[gi];
  end
  assign stage_wr = r_wr;

  for (genvar gj = 0; gj < NUM_SRC; gj++) begin : g_match
    dest_match #(
      .REG_W (REG_W),
      .DEPTH (DEPTH)
    ) u_dest_match (
      .i_src        (src_addr[gj*REG_W +: REG_W]),
      .i_stage_dest (stage_dest),
      .i_stage_wr   (r_wr),
      .o_hit        (src_hit[gj]),
      .o_hit_stage  (src_hit_stage[gj*SW +: SW])
    );
  end

endmodule

// File: tb/tb_ex_dest_pipe.sv
// Scoreboard bench: three configurations share one stimulus stream; a queue-based model
// predicts every cycle and a negedge monitor compares.
module tb_ex_dest_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] ex_rt = '0, ex_rd = '0;
  logic [1:0] ex_dst = '0;
  logic       ex_rw = 1'b0, ex_v = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [4:0] s0 = '0, s1 = '0, s2 = '0;

  logic [4:0]  d0_mux, d1_mux, d2_mux;
  logic [9:0]  d0_dest;
  logic [4:0]  d1_dest;
  logic [19:0] d2_dest;
  logic [1:0]  d0_wr;
  logic [0:0]  d1_wr;
  logic [3:0]  d2_wr;
  logic [1:0]  d0_hit, d0_hs;
  logic [2:0]  d1_hit, d1_hs, d2_hit;
  logic [5:0]  d2_hs;

  always #5 clk = ~clk;

  ex_dest_pipe #(.REG_W(5), .DEPTH(2), .LINK_REG(31), .NUM_SRC(2)) u_d0 (
    .clk (clk), .rst (rst), .EX_rt (ex_rt), .EX_rd (ex_rd), .EX_reg_dst (ex_dst),
    .EX_reg_write (ex_rw), .EX_valid (ex_v), .stall (stall), .flush (flush),
    .EX_rd_mux (d0_mux), .stage_dest (d0_dest), .stage_wr (d0_wr),
    .src_addr ({s1, s0}), .src_hit (d0_hit), .src_hit_stage (d0_hs)
  );

  ex_dest_pipe #(.REG_W(5), .DEPTH(1), .LINK_REG(31), .NUM_SRC(3)) u_d1 (
    .clk (clk), .rst (rst), .EX_rt (ex_rt), .EX_rd (ex_rd), .EX_reg_dst (ex_dst),
    .EX_reg_write (ex_rw), .EX_valid (ex_v), .stall (stall), .flush (flush),
    .EX_rd_mux (d1_mux), .stage_dest (d1_dest), .stage_wr (d1_wr),
    .src_addr ({s2, s1, s0}), .src_hit (d1_hit), .src_hit_stage (d1_hs)
  );

  ex_dest_pipe #(.REG_W(5), .DEPTH(4), .LINK_REG(31), .NUM_SRC(3)) u_d2 (
    .clk (clk), .rst (rst), .EX_rt (ex_rt), .EX_rd (ex_rd), .EX_reg_dst (ex_dst),
    .EX_reg_write (ex_rw), .EX_valid (ex_v), .stall (stall), .flush (flush),
    .EX_rd_mux (d2_mux), .stage_dest (d2_dest), .stage_wr (d2_wr),
    .src_addr ({s2, s1, s0}), .src_hit (d2_hit), .src_hit_stage (d2_hs)
  );

  typedef struct packed {
    logic [4:0] d;
    logic       w;
  } ent_t;

  typedef struct packed {
    logic [4:0]  mux;
    logic [19:0] dest;
    logic [3:0]  wr;
    logic [2:0]  hit;
    logic [5:0]  hs;
  } exp_t;

  // Model: per configuration, a list of in-flight entries ordered youngest first.
  ent_t m [3][4];
  int   dep  [3] = '{2, 1, 4};
  int   nsrc [3] = '{2, 3, 3};
  int   sw   [3] = '{1, 1, 2};

  exp_t q0[$], q1[$], q2[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [4:0] ref_dest();
    if (ex_dst == 2'd1) return ex_rd;
    if (ex_dst == 2'd2) return 5'd31;
    return ex_rt;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 4; i++) m[k][i] = '0;
  endtask

  // Advance the model by one clock edge using the inputs applied before that edge.
  task automatic model_step();
    ent_t nw;
    nw.d = ref_dest();
    nw.w = ex_v && ex_rw && (nw.d != 5'd0);
    if (flush) nw = '0;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int i = 0; i < 4; i++) m[k][i] = '0;
      end else if (stall) begin
        if (flush) m[k][0] = '0;
      end else begin
        for (int i = 3; i >= 1; i--) m[k][i] = m[k][i-1];
        m[k][0] = nw;
      end
    end
  endtask

  function automatic exp_t build(int k);
    exp_t       e;
    logic [4:0] src;
    int         idx;
    e     = '0;
    e.mux = ref_dest();
    for (int i = 0; i < dep[k]; i++) begin
      e.dest[i*5 +: 5] = m[k][i].d;
      e.wr[i]          = m[k][i].w;
    end
    for (int j = 0; j < nsrc[k]; j++) begin
      src = (j == 0) ? s0 : ((j == 1) ? s1 : s2);
      idx = 0;
      for (int i = 0; i < dep[k]; i++) begin
        if (src != 5'd0 && m[k][i].w && m[k][i].d == src) begin
          e.hit[j] = 1'b1;
          idx      = i;
          break;
        end
      end
      if (sw[k] == 1) e.hs[j] = idx[0];
      else            e.hs[j*2 +: 2] = idx[1:0];
    end
    return e;
  endfunction

  // One cycle of stimulus: wait for the edge, advance the model, apply new inputs,
  // then queue what the DUTs must show before the next edge.
  task automatic cyc(input logic [4:0] rt, input logic [4:0] rd, input logic [1:0] dst,
                     input logic rw, input logic v, input logic st, input logic fl,
                     input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                     input logic r);
    @(posedge clk);
    model_step();
    #1;
    ex_rt = rt; ex_rd = rd; ex_dst = dst; ex_rw = rw; ex_v = v;
    stall = st; flush = fl; s0 = a0; s1 = a1; s2 = a2; rst = r;
    if (r) model_reset();
    q0.push_back(build(0));
    q1.push_back(build(1));
    q2.push_back(build(2));
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  exp_t me;

  // Monitor: compare whatever the scoreboard expects for this cycle.
  always @(negedge clk) begin
    if (q0.size() != 0) begin
      me = q0.pop_front();
      chk("d0_mux", 32'(d0_mux), 32'(me.mux));
      chk("d0_dest", 32'(d0_dest), 32'(me.dest));
      chk("d0_wr", 32'(d0_wr), 32'(me.wr));
      chk("d0_hit", 32'(d0_hit), 32'(me.hit));
      chk("d0_hit_stage", 32'(d0_hs), 32'(me.hs));
    end
    if (q1.size() != 0) begin
      me = q1.pop_front();
      chk("d1_mux", 32'(d1_mux), 32'(me.mux));
      chk("d1_dest", 32'(d1_dest), 32'(me.dest));
      chk("d1_wr", 32'(d1_wr), 32'(me.wr));
      chk("d1_hit", 32'(d1_hit), 32'(me.hit));
      chk("d1_hit_stage", 32'(d1_hs), 32'(me.hs));
    end
    if (q2.size() != 0) begin
      me = q2.pop_front();
      chk("d2_mux", 32'(d2_mux), 32'(me.mux));
      chk("d2_dest", 32'(d2_dest), 32'(me.dest));
      chk("d2_wr", 32'(d2_wr), 32'(me.wr));
      chk("d2_hit", 32'(d2_hit), 32'(me.hit));
      chk("d2_hit_stage", 32'(d2_hs), 32'(me.hs));
    end
  end

  function automatic logic [4:0] rnd_reg();
    int v;
    v = $urandom_range(0, 8);
    return (v == 8) ? 5'd31 : 5'(v);
  endfunction

  initial begin
    model_reset();
    // Reset held across two edges.
    cyc(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    cyc(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
    // Mode select, all four codes.
    for (int d = 0; d < 4; d++)
      cyc(5'h15, 5'h0A, 2'(d), 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    // Two writes to r8, then bubbles drain them; rs=8 rt=9.
    cyc(5'd0, 5'd8, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 5'd9, 5'd8, 1'b0);
    cyc(5'd0, 5'd8, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd8, 5'd9, 5'd8, 1'b0);
    for (int n = 0; n < 4; n++)
      cyc(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 5'd9, 5'd8, 1'b0);
    // Write to $0 and a non-valid write to r5 must never hit.
    cyc(5'd0, 5'd0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 1'b0);
    cyc(5'd0, 5'd5, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 1'b0);
    cyc(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 1'b0);
    cyc(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd5, 1'b0);
    // r3 enters, stall three cycles, then stall+flush with r4 at EX.
    cyc(5'd0, 5'd3, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 5'd9, 1'b0);
    cyc(5'd0, 5'd9, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 5'd9, 1'b0);
    for (int n = 0; n < 3; n++)
      cyc(5'd0, 5'd9, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 5'd4, 5'd9, 1'b0);
    cyc(5'd0, 5'd4, 2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3, 5'd4, 5'd9, 1'b0);
    cyc(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 5'd9, 1'b0);
    cyc(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 5'd9, 1'b0);
    // Link writes, then an asynchronous reset mid-stream checked before the next edge.
    cyc(5'd0, 5'd6, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 5'd31, 5'd6, 5'd7, 1'b0);
    cyc(5'd0, 5'd7, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd31, 5'd6, 5'd7, 1'b0);
    cyc(5'd0, 5'd6, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd31, 5'd6, 5'd7, 1'b0);
    cyc(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 5'd6, 5'd7, 1'b1);
    cyc(5'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd31, 5'd6, 5'd7, 1'b0);
    // Randomized traffic on a small register range so hits are frequent.
    for (int n = 0; n < 600; n++) begin
      cyc(rnd_reg(), rnd_reg(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) != 0),
          1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 6) == 0), rnd_reg(), rnd_reg(), rnd_reg(),
          1'($urandom_range(0, 60) == 0));
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (q0.size() != 0 || q1.size() != 0 || q2.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain act=%0d exp=0", q0.size() + q1.size() + q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
